// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_out_q, borrow_out_d;
  logic             bit_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    br_d         = br_q;
    borrow_out_d = borrow_out_q;
    bit_d        = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
        br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // Last bit lands in the MSB on this edge, so publish res_d, not res_q.
        if (cnt_q == LAST) begin
          diff_d       = res_d;
          borrow_out_d = br_d;
          state_d      = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d        = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      br_q         <= br_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule
